freq_meter: RTL and testbench

Measures the frequency of an asynchronous digital input by counting its rising edges over a fixed gate window of `clkin` cycles. At the end of every window it publishes the edge count with a one-cycle `valid` strobe. It is the input-side counterpart of the prescaler/LED counter path: the prescaler turns `clkin` into a 1 Hz tick, and this block turns an external pulse train back into a number. With default parameters the window is 1 s at 25 MHz, so `count` reads directly in Hz.

---
 rtl/freq_meter.sv | 51 +++++
 tb/tb_freq_meter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_in over a fixed gate window and publishes the total with a valid strobe.
module freq_meter #(
  parameter int GATE_CYCLES = 25000000,
  parameter int GATE_BITS = 25,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  sig_in,
  output logic [COUNT_BITS-1:0] count,
  output logic                  valid,
  output logic                  overflow
);
  logic s1, s2, s3, sat, rise, last, at_max;
  logic [GATE_BITS-1:0] gate_cnt;
  logic [COUNT_BITS-1:0] acc;
  always_comb begin
    rise = s2 & ~s3;
    last = gate_cnt == GATE_BITS'(GATE_CYCLES - 1);
    at_max = &acc;
  end
  // An edge in the closing cycle is folded straight into the published count.
  always_ff @(posedge clkin) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      gate_cnt <= '0;
      acc <= '0;
      sat <= 1'b0;
      count <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
      gate_cnt <= last ? '0 : gate_cnt + 1'b1;
      valid <= last;
      if (last) begin
        count <= acc + COUNT_BITS'(rise & ~at_max);
        overflow <= sat | (at_max & rise);
        acc <= '0;
        sat <= 1'b0;
      end else if (rise) begin
        acc <= at_max ? acc : acc + 1'b1;
        sat <= sat | at_max;
      end
    end
  end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of two freq_meter instances (8-bit and 4-bit accumulators) sharing one stimulus.
module tb_freq_meter;
  logic clkin = 1'b0, rst = 1'b1, sig_in = 1'b0;
  logic [7:0] count_a;
  logic [3:0] count_b;
  logic valid_a, overflow_a, valid_b, overflow_b;
  int cyc = 0, half = 0, ph = 0, asserts = 0, fails = 0;

  always #5 clkin = ~clkin;

  freq_meter #(.GATE_CYCLES(100), .GATE_BITS(7), .COUNT_BITS(8)) dut_a (
    .clkin(clkin), .rst(rst), .sig_in(sig_in),
    .count(count_a), .valid(valid_a), .overflow(overflow_a)
  );
  freq_meter #(.GATE_CYCLES(100), .GATE_BITS(7), .COUNT_BITS(4)) dut_b (
    .clkin(clkin), .rst(rst), .sig_in(sig_in),
    .count(count_b), .valid(valid_b), .overflow(overflow_b)
  );

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    asserts++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock per call; inputs change and outputs are sampled on the falling edge.
  task automatic step;
    @(negedge clkin);
    cyc++;
    if (half > 0) begin
      ph++;
      if (ph >= half) begin
        ph = 0;
        sig_in = ~sig_in;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    half = 0;
    sig_in = 1'b0;
    rst = 1'b1;
    repeat (3) step;
    chk(32'(count_a), 0, {tag, " rst count_a"});
    chk(32'(valid_a), 0, {tag, " rst valid_a"});
    chk(32'(overflow_a), 0, {tag, " rst overflow_a"});
    chk(32'(count_b), 0, {tag, " rst count_b"});
    chk(32'(valid_b), 0, {tag, " rst valid_b"});
    chk(32'(overflow_b), 0, {tag, " rst overflow_b"});
    rst = 1'b0;
    cyc = 0;
    ph = 0;
  endtask

  task automatic wait_valid(input int exp_cyc, input bit full, input int ea, input int oa,
                            input int eb, input int ob, input string tag);
    do step; while (!valid_a && cyc < exp_cyc + 50);
    chk(32'(cyc), 32'(exp_cyc), {tag, " valid cycle"});
    chk(32'(valid_b), 1, {tag, " valid_b"});
    if (full) begin
      chk(32'(count_a), 32'(ea), {tag, " count_a"});
      chk(32'(overflow_a), 32'(oa), {tag, " overflow_a"});
      chk(32'(count_b), 32'(eb), {tag, " count_b"});
      chk(32'(overflow_b), 32'(ob), {tag, " overflow_b"});
    end
    step;
    chk(32'(valid_a), 0, {tag, " valid width"});
  endtask

  initial begin
    do_reset("idle");
    wait_valid(100, 1, 0, 0, 0, 0, "idle w1");
    wait_valid(200, 1, 0, 0, 0, 0, "idle w2");
    wait_valid(300, 1, 0, 0, 0, 0, "idle w3");

    do_reset("square");
    half = 5;
    wait_valid(100, 0, 0, 0, 0, 0, "square w1");
    wait_valid(200, 1, 10, 0, 10, 0, "square w2");
    wait_valid(300, 1, 10, 0, 10, 0, "square w3");

    do_reset("sat");
    half = 2;
    wait_valid(100, 0, 0, 0, 0, 0, "sat w1");
    wait_valid(200, 1, 25, 0, 15, 1, "sat w2");
    chk(32'(overflow_b), 1, "sat hold overflow_b");
    chk(32'(count_b), 15, "sat hold count_b");
    half = 0;
    sig_in = 1'b0;
    wait_valid(300, 0, 0, 0, 0, 0, "sat w3");
    wait_valid(400, 1, 0, 0, 0, 0, "sat w4");

    do_reset("bound");
    while (cyc < 97) step;
    sig_in = 1'b1;
    wait_valid(100, 1, 1, 0, 1, 0, "bound last");
    wait_valid(200, 1, 0, 0, 0, 0, "bound after last");
    sig_in = 1'b0;
    while (cyc < 298) step;
    sig_in = 1'b1;
    wait_valid(300, 1, 0, 0, 0, 0, "bound before first");
    wait_valid(400, 1, 1, 0, 1, 0, "bound first");

    do_reset("midrst pre");
    repeat (5) begin
      sig_in = 1'b1;
      repeat (2) step;
      sig_in = 1'b0;
      repeat (2) step;
    end
    while (cyc < 50) step;
    do_reset("midrst");
    repeat (2) begin
      sig_in = 1'b1;
      repeat (2) step;
      sig_in = 1'b0;
      repeat (2) step;
    end
    wait_valid(100, 1, 2, 0, 2, 0, "midrst w1");

    do_reset("maxrate");
    half = 1;
    wait_valid(100, 0, 0, 0, 0, 0, "maxrate w1");
    wait_valid(200, 1, 50, 0, 15, 1, "maxrate w2");
    wait_valid(300, 1, 50, 0, 15, 1, "maxrate w3");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
